jescpu_core: RTL and testbench

- Parametrised successor to the 8-bit memory-to-memory CPU.
- Same 12-opcode ISA; data width, address width and I/O port count are generalised.
- Adds a variable-latency req/ack memory interface, working IN, multiple output ports, a run/pause control and a sticky halt with a reason code.
- Sits between the board top level (LED scan, RAM) and a memory or arbiter.

---
 rtl/jescpu_pkg.sv | 49 ++++
 rtl/jescpu_alu.sv | 35 +++
 rtl/jescpu_core.sv | 230 +++++++++++++++++++++++
 tb/tb_jescpu_core.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jescpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jescpu_pkg
// Description : Shared constants for the jescpu core: opcodes, sequencer
//               states, halt reason codes and instruction lengths.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package jescpu_pkg;

    // Opcode map; anything at or above NUMOPS is illegal
    localparam int NUMOPS = 12;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_JZ   = 4'd2;
    localparam logic [3:0] OP_COPY = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_OUT  = 4'd10;
    localparam logic [3:0] OP_IN   = 4'd11;

    // Sequencer states
    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_LA   = 3'd3,
        S_LB   = 3'd4,
        S_EXEC = 3'd5,
        S_WR   = 3'd6,
        S_HALT = 3'd7
    } state_e;

    // Halt reason codes
    localparam logic [1:0] HALT_NONE  = 2'd0;
    localparam logic [1:0] HALT_ILLOP = 2'd1;
    localparam logic [1:0] HALT_PORT  = 2'd2;

    // Instruction lengths in words
    localparam int LEN_NOP = 1;
    localparam int LEN_NOT = 2;
    localparam int LEN_STD = 3;

endpackage
`default_nettype wire

// File: rtl/jescpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : jescpu_alu
// Description : Combinational data path for the write-back opcodes; all
//               results wrap modulo 2^DW.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module jescpu_alu
    import jescpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    i_opcode,
    input  logic [DW-1:0] i_v1,
    input  logic [DW-1:0] i_v2,
    output logic [DW-1:0] o_result
);

    // Result selection by opcode; non-ALU opcodes yield zero
    always_comb begin
        o_result = '0;
        case (i_opcode)
            OP_COPY: o_result = i_v2;
            OP_ADD:  o_result = i_v1 + i_v2;
            OP_SUB:  o_result = i_v1 - i_v2;
            OP_XOR:  o_result = i_v1 ^ i_v2;
            OP_AND:  o_result = i_v1 & i_v2;
            OP_OR:   o_result = i_v1 | i_v2;
            OP_NOT:  o_result = ~i_v1;
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/jescpu_core.sv
`default_nettype none
// ============================================================================
// Module      : jescpu_core
// Description : Parametrised memory-to-memory CPU with a req/ack memory port,
//               NPORTS I/O ports, run/pause control and sticky halt.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module jescpu_core
    import jescpu_pkg::*;
#(
    parameter int            DW       = 8,
    parameter int            AW       = 8,
    parameter int            NPORTS   = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_ack,
    input  logic [NPORTS*DW-1:0] in_data,
    output logic [NPORTS*DW-1:0] out_data,
    output logic [NPORTS-1:0]    out_stb,
    output logic                 retire,
    output logic                 halted,
    output logic [1:0]           halt_code,
    output logic [AW-1:0]        pc
);

    state_e              r_state;
    logic [AW-1:0]       r_pc;
    logic [AW-1:0]       r_op1;
    logic [AW-1:0]       r_op2;
    logic [3:0]          r_opc;
    logic [DW-1:0]       r_v1;
    logic [DW-1:0]       r_v2;
    logic [DW-1:0]       r_result;
    logic                r_busy;
    logic                r_retire;
    logic [NPORTS-1:0]   r_stb;
    logic                r_halted;
    logic [1:0]          r_halt_code;
    logic [DW-1:0]       r_out [NPORTS];

    logic                w_mem_state;
    logic                w_done;
    logic [DW-1:0]       w_alu;
    logic [DW-1:0]       w_in_sel;
    logic                w_port_ok;

    jescpu_alu #(.DW(DW)) u_alu (
        .i_opcode (r_opc),
        .i_v1     (r_v1),
        .i_v2     (r_v2),
        .o_result (w_alu)
    );

    // Request qualification: an opcode fetch only launches while running,
    // but once launched (r_busy) it is held until acknowledged
    always_comb begin
        w_mem_state = 1'b0;
        case (r_state)
            S_OP:                          w_mem_state = run | r_busy;
            S_A, S_B, S_LA, S_LB, S_WR:    w_mem_state = 1'b1;
            default:                       w_mem_state = 1'b0;
        endcase
    end

    assign mem_req   = ~rst & w_mem_state;
    assign mem_we    = ~rst & (r_state == S_WR);
    assign mem_wdata = r_result;
    assign w_done    = mem_req & mem_ack;

    // Address source per state; all sources are registers so they stay
    // stable for the whole transaction
    always_comb begin
        mem_addr = r_pc;
        case (r_state)
            S_A:     mem_addr = r_pc + AW'(1);
            S_B:     mem_addr = r_pc + AW'(2);
            S_LA:    mem_addr = r_op1;
            S_LB:    mem_addr = r_op2;
            S_WR:    mem_addr = r_op1;
            default: mem_addr = r_pc;
        endcase
    end

    // Input port select and port-range check on operand2
    always_comb begin
        w_in_sel  = '0;
        w_port_ok = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (int'(r_op2) == p) begin
                w_in_sel  = in_data[p*DW +: DW];
                w_port_ok = 1'b1;
            end
        end
    end

    // Instruction sequencer with registered port, retire and halt outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_OP;
            r_pc        <= RESET_PC;
            r_op1       <= '0;
            r_op2       <= '0;
            r_opc       <= OP_NOP;
            r_v1        <= '0;
            r_v2        <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_retire    <= 1'b0;
            r_stb       <= '0;
            r_halted    <= 1'b0;
            r_halt_code <= HALT_NONE;
            for (int p = 0; p < NPORTS; p++) r_out[p] <= '0;
        end else begin
            r_retire <= 1'b0;
            r_stb    <= '0;
            r_busy   <= (r_state == S_OP) && mem_req && !mem_ack;
            case (r_state)
                S_OP: if (w_done) begin
                    if (mem_rdata == DW'(OP_NOP)) begin
                        r_pc     <= r_pc + AW'(LEN_NOP);
                        r_retire <= 1'b1;
                    end else if (mem_rdata >= DW'(NUMOPS)) begin
                        r_state     <= S_HALT;
                        r_halted    <= 1'b1;
                        r_halt_code <= HALT_ILLOP;
                    end else begin
                        r_opc   <= mem_rdata[3:0];
                        r_state <= S_A;
                    end
                end
                S_A: if (w_done) begin
                    r_op1 <= mem_rdata[AW-1:0];
                    if (r_opc == OP_JMP)      r_state <= S_EXEC;
                    else if (r_opc == OP_NOT) r_state <= S_LA;
                    else                      r_state <= S_B;
                end
                S_B: if (w_done) begin
                    r_op2 <= mem_rdata[AW-1:0];
                    if (r_opc == OP_COPY)    r_state <= S_LB;
                    else if (r_opc == OP_IN) r_state <= S_EXEC;
                    else                     r_state <= S_LA;
                end
                S_LA: if (w_done) begin
                    r_v1 <= mem_rdata;
                    if (r_opc == OP_NOT || r_opc == OP_JZ || r_opc == OP_OUT)
                        r_state <= S_EXEC;
                    else
                        r_state <= S_LB;
                end
                S_LB: if (w_done) begin
                    r_v2    <= mem_rdata;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (r_opc)
                        OP_JMP: begin
                            r_pc     <= r_op1;
                            r_retire <= 1'b1;
                            r_state  <= S_OP;
                        end
                        OP_JZ: begin
                            r_pc     <= (r_v1 == '0) ? r_op2 : r_pc + AW'(LEN_STD);
                            r_retire <= 1'b1;
                            r_state  <= S_OP;
                        end
                        OP_OUT: begin
                            if (w_port_ok) begin
                                for (int p = 0; p < NPORTS; p++) begin
                                    if (int'(r_op2) == p) begin
                                        r_out[p] <= r_v1;
                                        r_stb[p] <= 1'b1;
                                    end
                                end
                                r_pc     <= r_pc + AW'(LEN_STD);
                                r_retire <= 1'b1;
                                r_state  <= S_OP;
                            end else begin
                                r_state     <= S_HALT;
                                r_halted    <= 1'b1;
                                r_halt_code <= HALT_PORT;
                            end
                        end
                        OP_IN: begin
                            if (w_port_ok) begin
                                r_result <= w_in_sel;
                                r_state  <= S_WR;
                            end else begin
                                r_state     <= S_HALT;
                                r_halted    <= 1'b1;
                                r_halt_code <= HALT_PORT;
                            end
                        end
                        default: begin
                            r_result <= w_alu;
                            r_state  <= S_WR;
                        end
                    endcase
                end
                S_WR: if (w_done) begin
                    r_pc     <= r_pc + ((r_opc == OP_NOT) ? AW'(LEN_NOT) : AW'(LEN_STD));
                    r_retire <= 1'b1;
                    r_state  <= S_OP;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
            assign out_data[gp*DW +: DW] = r_out[gp];
        end
    endgenerate

    assign out_stb   = r_stb;
    assign retire    = r_retire;
    assign halted    = r_halted;
    assign halt_code = r_halt_code;
    assign pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_jescpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_jescpu_core
// Description : Self-checking bench: directed scenarios plus random programs
//               compared against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jescpu_core;
    import jescpu_pkg::*;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [31:0] in_data = '0;
    logic [31:0] out_data;
    logic [3:0]  out_stb;
    logic        retire, halted;
    logic [1:0]  halt_code;
    logic [7:0]  pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jescpu_core #(.DW(8), .AW(8), .NPORTS(NP), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .in_data(in_data), .out_data(out_data), .out_stb(out_stb),
        .retire(retire), .halted(halted), .halt_code(halt_code), .pc(pc)
    );

    // Memory with programmable ack latency; image loaded on the load flag
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load = 1'b0;
    int         lat = 0;
    int         r_wait = 0;

    assign mem_ack   = mem_req && (r_wait >= lat);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_req && mem_ack) r_wait <= 0;
        else if (mem_req)       r_wait <= r_wait + 1;
        else                    r_wait <= 0;
    end

    // Handshake stability monitor: addr/we/wdata frozen while unacked
    logic [7:0] prev_addr = '0, prev_wdata = '0;
    logic       prev_we = 1'b0, prev_pend = 1'b0;
    int         stab_err = 0;
    always @(posedge clk) begin
        if (prev_pend && mem_req &&
            (mem_addr != prev_addr || mem_we != prev_we || (mem_we && mem_wdata != prev_wdata)))
            stab_err <= stab_err + 1;
        prev_pend  <= mem_req && !mem_ack && !rst;
        prev_addr  <= mem_addr;
        prev_we    <= mem_we;
        prev_wdata <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    // Hold reset for two edges, loading the image on the first
    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic wait_evt(input int budget, output int cyc, output bit got_ret, output bit got_halt);
        cyc = 0; got_ret = 1'b0; got_halt = 1'b0;
        while (cyc < budget && !got_ret && !got_halt) begin
            tick();
            cyc++;
            if (retire)      got_ret  = 1'b1;
            else if (halted) got_halt = 1'b1;
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [7:0] mm [256];
    logic [7:0] mpc;
    logic [7:0] mout [NP];

    task automatic model_step(output int kind, output logic [3:0] stb);
        logic [7:0] op, a, b, va, vb, res, p1, p2;
        bit wr;
        kind = 0; stb = '0; wr = 1'b0; res = '0;
        p1 = mpc + 8'd1;
        p2 = mpc + 8'd2;
        op = mm[mpc]; a = mm[p1]; b = mm[p2];
        va = mm[a];   vb = mm[b];
        if (op == 8'd0) begin
            mpc = mpc + 8'd1;
        end else if (op >= 8'd12) begin
            kind = 1;
        end else begin
            case (op[3:0])
                OP_JMP:  mpc = a;
                OP_JZ:   mpc = (va == 8'd0) ? b : mpc + 8'd3;
                OP_OUT:  if (b >= 8'd4) kind = 2;
                         else begin mout[b[1:0]] = va; stb[b[1:0]] = 1'b1; mpc = mpc + 8'd3; end
                OP_IN:   if (b >= 8'd4) kind = 2;
                         else begin res = in_data[b[1:0]*8 +: 8]; wr = 1'b1; end
                OP_NOT:  begin res = ~va;     wr = 1'b1; end
                OP_COPY: begin res = vb;      wr = 1'b1; end
                OP_ADD:  begin res = va + vb; wr = 1'b1; end
                OP_SUB:  begin res = va - vb; wr = 1'b1; end
                OP_XOR:  begin res = va ^ vb; wr = 1'b1; end
                OP_AND:  begin res = va & vb; wr = 1'b1; end
                default: begin res = va | vb; wr = 1'b1; end
            endcase
            if (wr) begin
                mm[a] = res;
                mpc = mpc + ((op[3:0] == OP_NOT) ? 8'd2 : 8'd3);
            end
        end
    endtask

    task automatic gen_program();
        int a;
        logic [3:0] op;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        a = 0;
        while (a < 8'h3C) begin
            op = 4'($urandom_range(0, 11));
            img[a]   = {4'h0, op};
            img[a+1] = 8'(8'h80 + $urandom_range(0, 127));
            img[a+2] = 8'(8'h80 + $urandom_range(0, 127));
            if (op == OP_JMP) img[a+1] = 8'($urandom_range(0, 8'h3B));
            if (op == OP_JZ)  img[a+2] = 8'($urandom_range(0, 8'h3B));
            if (op == OP_OUT || op == OP_IN)
                img[a+2] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(4, 7))
                                                       : 8'($urandom_range(0, 3));
            a += (op == OP_NOP) ? 1 : ((op == OP_NOT) ? 2 : 3);
        end
    endtask

    task automatic run_random();
        int cyc, kind, nmis;
        bit gr, gh;
        logic [3:0] estb;
        gen_program();
        for (int i = 0; i < 256; i++) mm[i] = img[i];
        for (int p = 0; p < NP; p++) mout[p] = '0;
        mpc     = 8'h00;
        lat     = $urandom_range(0, 2);
        in_data = $urandom;
        run     = 1'b1;
        do_reset();
        rst = 1'b0;
        for (int ev = 0; ev < 25; ev++) begin
            wait_evt(200, cyc, gr, gh);
            if (!gr && !gh) begin
                check("rnd_timeout", 32'd0, 32'd1);
                break;
            end
            model_step(kind, estb);
            check("rnd_kind", gh ? {30'd0, halt_code} : 32'd0, kind);
            check("rnd_pc", {24'd0, pc}, {24'd0, mpc});
            if (gh || kind != 0) break;
            check("rnd_stb", {28'd0, out_stb}, {28'd0, estb});
            check("rnd_out", out_data, {mout[3], mout[2], mout[1], mout[0]});
        end
        run = 1'b0;
        repeat (3) tick();
        nmis = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) nmis++;
        check("rnd_mem", nmis, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cyc, nret, nreq;
        bit gr, gh;

        // ADD with wrap, zero wait
        clear_img();
        img[0] = {4'h0, OP_ADD}; img[1] = 8'h10; img[2] = 8'h11;
        img[8'h10] = 8'hF0; img[8'h11] = 8'h20;
        lat = 0; run = 1'b1;
        do_reset();
        check("rst_req", mem_req, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        check("rst_code", halt_code, 0);
        check("rst_out", out_data, 0);
        check("rst_stb", out_stb, 0);
        check("rst_pc", pc, 0);
        rst = 1'b0;
        wait_evt(50, cyc, gr, gh);
        run = 1'b0;
        check("add_cycles", cyc, 7);
        check("add_pc", pc, 3);
        check("add_result", mem[8'h10], 8'h10);
        tick();
        check("retire_pulse", retire, 0);

        // ADD with two wait states per transaction
        lat = 2; run = 1'b1;
        do_reset();
        rst = 1'b0;
        wait_evt(100, cyc, gr, gh);
        run = 1'b0;
        check("add_wait_cycles", cyc, 19);
        check("add_wait_result", mem[8'h10], 8'h10);
        check("add_wait_pc", pc, 3);

        // OUT to port 2
        clear_img();
        img[0] = {4'h0, OP_OUT}; img[1] = 8'h20; img[2] = 8'h02; img[8'h20] = 8'hA5;
        lat = 0; run = 1'b1;
        do_reset();
        rst = 1'b0;
        wait_evt(50, cyc, gr, gh);
        run = 1'b0;
        check("out_cycles", cyc, 5);
        check("out_port2", out_data[23:16], 8'hA5);
        check("out_stb", out_stb, 4'b0100);
        tick();
        check("out_stb_clear", out_stb, 4'b0000);
        check("out_hold", out_data, 32'h00A5_0000);

        // IN from port 1
        clear_img();
        img[0] = {4'h0, OP_IN}; img[1] = 8'h30; img[2] = 8'h01;
        in_data = 32'h1122_3C44;
        run = 1'b1;
        do_reset();
        check("rst_clears_out", out_data, 0);
        rst = 1'b0;
        wait_evt(50, cyc, gr, gh);
        run = 1'b0;
        check("in_result", mem[8'h30], 8'h3C);
        check("in_pc", pc, 3);

        // Illegal opcode after five NOPs
        clear_img();
        img[5] = 8'h0C;
        run = 1'b1;
        do_reset();
        rst = 1'b0;
        nret = 0;
        for (int i = 0; i < 50 && !halted; i++) begin
            tick();
            if (retire) nret++;
        end
        check("illop_retires", nret, 5);
        check("illop_halted", halted, 1);
        check("illop_code", halt_code, 1);
        check("illop_pc", pc, 5);
        repeat (3) tick();
        check("illop_noreq", mem_req, 0);

        // Illegal port
        clear_img();
        img[0] = {4'h0, OP_OUT}; img[1] = 8'h20; img[2] = 8'h04;
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 50 && !halted; i++) tick();
        check("port_halted", halted, 1);
        check("port_code", halt_code, 2);
        check("port_pc", pc, 0);
        rst = 1'b1;
        tick();
        check("halt_clear", halted, 0);
        check("code_clear", halt_code, 0);

        // JZ taken / not taken
        clear_img();
        img[0] = {4'h0, OP_JZ}; img[1] = 8'h40; img[2] = 8'h80;
        do_reset();
        rst = 1'b0;
        wait_evt(50, cyc, gr, gh);
        check("jz_taken_pc", pc, 8'h80);
        img[8'h40] = 8'h01;
        do_reset();
        rst = 1'b0;
        wait_evt(50, cyc, gr, gh);
        check("jz_fall_pc", pc, 8'h03);

        // Three-byte instruction at 0xFE wraps to 0x01
        clear_img();
        img[0] = {4'h0, OP_JMP}; img[1] = 8'hFE;
        img[8'hFE] = {4'h0, OP_JZ}; img[8'hFF] = 8'h40; img[8'h40] = 8'h01;
        do_reset();
        rst = 1'b0;
        wait_evt(50, cyc, gr, gh);
        check("jmp_pc", pc, 8'hFE);
        wait_evt(50, cyc, gr, gh);
        run = 1'b0;
        check("wrap_pc", pc, 8'h01);

        // Pause requested in the middle of an ADD
        clear_img();
        img[0] = {4'h0, OP_ADD}; img[1] = 8'h10; img[2] = 8'h11;
        img[8'h10] = 8'h05; img[8'h11] = 8'h03;
        lat = 1; run = 1'b1;
        do_reset();
        rst = 1'b0;
        repeat (3) tick();
        run = 1'b0;
        wait_evt(50, cyc, gr, gh);
        check("pause_retire", gr, 1);
        check("pause_result", mem[8'h10], 8'h08);
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_req) nreq++;
        end
        check("pause_noreq", nreq, 0);
        check("pause_pc", pc, 3);
        run = 1'b1;
        wait_evt(50, cyc, gr, gh);
        run = 1'b0;
        check("resume_pc", pc, 4);

        // Reset while a request is pending
        lat = 5; run = 1'b1;
        do_reset();
        rst = 1'b0;
        tick(); tick();
        check("pend_req", {mem_req, mem_ack}, 2'b10);
        rst = 1'b1;
        tick();
        check("abort_req", mem_req, 0);
        check("abort_pc", pc, 0);
        run = 1'b0;

        // Random programs against the reference model
        for (int t = 0; t < 8; t++) run_random();

        check("handshake_stable", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
